// File: rtl/mem_pkg.sv
// ---------------------------------------------------------------------------
// mem_pkg
// Shared types and constants for the data-memory arbiter.
//   arb_state_t     : arbitration FSM states (ARB = no owner, OWNx = port x
//                     holds a lock).
//   IO_ADDR_DEFAULT : default address of the memory-mapped output register.
//   port_req_t      : one requester's request bundle at the default 8-bit
//                     address/data widths.
// ---------------------------------------------------------------------------
package mem_pkg;

    typedef enum logic [1:0] {
        ARB  = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

    localparam logic [7:0] IO_ADDR_DEFAULT = 8'hFF;

    typedef struct packed {
        logic       req;
        logic       we;
        logic       lock;
        logic [7:0] addr;
        logic [7:0] wdata;
    } port_req_t;

endpackage

// File: rtl/rr_pick2.sv
// ---------------------------------------------------------------------------
// rr_pick2
// Two-input round-robin picker, purely combinational.
//   req[1:0]  in  : request per port
//   last      in  : index of the port granted most recently
//   pick[1:0] out : one-hot pick (all zero when nobody requests)
// On contention the port that was not granted last wins.
// ---------------------------------------------------------------------------
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] pick
);

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        pick = 2'b00;
        case (req)
            2'b01:   pick = 2'b01;
            2'b10:   pick = 2'b10;
            2'b11:   pick = last ? 2'b01 : 2'b10;
            default: pick = 2'b00;
        endcase
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// ---------------------------------------------------------------------------
// data_mem_arbiter
// Shares the single-port data Memory between port 0 (CPU data) and port 1
// (loader/debug). Round-robin arbitration with an optional bounded lock for
// atomic sequences. Writes to IO_ADDR land in the output register instead of
// Memory; reads of IO_ADDR return that register.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   reqN, weN, lockN         : request, write enable, keep-ownership flag
//   addrN, wdataN            : access address and write data
//   gntN                     : combinational grant, access completes at edge
//   rdataN, rvalidN          : registered read data and one-cycle valid pulse
//   mem_address, mem_in,
//   mem_wr_enable            : to Memory.address / .in / .writeEnable
//   mem_out                  : from Memory.out (combinational read)
//   io_data, io_valid        : output register and its one-cycle update pulse
// ---------------------------------------------------------------------------
module data_mem_arbiter
    import mem_pkg::*;
#(
    parameter int              AW       = 8,
    parameter int              DW       = 8,
    parameter logic [AW-1:0]   IO_ADDR  = AW'(IO_ADDR_DEFAULT),
    parameter int              LOCK_MAX = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic          lock0,
    input  logic          lock1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          gnt0,
    output logic          gnt1,
    output logic [DW-1:0] rdata0,
    output logic [DW-1:0] rdata1,
    output logic          rvalid0,
    output logic          rvalid1,
    output logic [AW-1:0] mem_address,
    output logic [DW-1:0] mem_in,
    input  logic [DW-1:0] mem_out,
    output logic          mem_wr_enable,
    output logic [DW-1:0] io_data,
    output logic          io_valid
);

    localparam logic [3:0] LOCK_CNT_MAX = 4'(LOCK_MAX);

    arb_state_t    state, state_nxt;
    logic          last, last_nxt;
    logic [3:0]    lock_cnt, lock_cnt_nxt;
    logic [3:0]    cnt_inc;

    logic [1:0]    pick;
    logic [1:0]    gnt;
    logic          any_gnt;
    logic          sel;
    logic          sel_we;
    logic          sel_lock;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;
    logic          sel_is_io;
    logic          rd_fire;
    logic          io_fire;
    logic [DW-1:0] rd_value;

    rr_pick2 u_pick (
        .req  ({req1, req0}),
        .last (last),
        .pick (pick)
    );

    // Grant: the picker decides only when nobody owns the arbiter; an owner
    // gets the slot whenever it requests and the other port stalls. Grants
    // are held off during reset so outputs show their reset values.
    always_comb begin
        gnt = 2'b00;
        if (!rst) begin
            case (state)
                ARB:     gnt = pick;
                OWN0:    gnt = {1'b0, req0};
                OWN1:    gnt = {req1, 1'b0};
                default: gnt = 2'b00;
            endcase
        end
    end

    assign gnt0      = gnt[0];
    assign gnt1      = gnt[1];
    assign any_gnt   = |gnt;
    assign sel       = gnt[1];
    assign sel_we    = sel ? we1    : we0;
    assign sel_lock  = sel ? lock1  : lock0;
    assign sel_addr  = sel ? addr1  : addr0;
    assign sel_wdata = sel ? wdata1 : wdata0;
    assign sel_is_io = (sel_addr == IO_ADDR);
    assign rd_fire   = any_gnt & ~sel_we;
    assign io_fire   = any_gnt & sel_we & sel_is_io;
    assign rd_value  = sel_is_io ? io_data : mem_out;

    // Memory pins idle at zero address when nobody is granted.
    assign mem_address   = any_gnt ? sel_addr  : '0;
    assign mem_in        = any_gnt ? sel_wdata : '0;
    assign mem_wr_enable = any_gnt & sel_we & ~sel_is_io;

    assign cnt_inc = lock_cnt + 4'd1;

    // The grant cycle in ARB counts as the first owned cycle, so the owner
    // holds the arbiter for at most LOCK_CNT_MAX consecutive cycles; with a
    // limit of 1 the lock expires before OWNx is ever entered.
    always_comb begin
        state_nxt    = state;
        last_nxt     = last;
        lock_cnt_nxt = lock_cnt;
        case (state)
            ARB: begin
                if (any_gnt) begin
                    last_nxt = sel;
                    if (sel_lock) begin
                        lock_cnt_nxt = 4'd1;
                        if (LOCK_CNT_MAX == 4'd1) begin
                            lock_cnt_nxt = 4'd0;
                        end else if (sel) begin
                            state_nxt = OWN1;
                        end else begin
                            state_nxt = OWN0;
                        end
                    end
                end
            end
            OWN0, OWN1: begin
                lock_cnt_nxt = cnt_inc;
                if ((any_gnt && !sel_lock) || (cnt_inc == LOCK_CNT_MAX)) begin
                    state_nxt    = ARB;
                    lock_cnt_nxt = 4'd0;
                    last_nxt     = (state == OWN1);
                end
            end
            default: begin
                state_nxt    = ARB;
                lock_cnt_nxt = 4'd0;
            end
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ARB;
            last     <= 1'b1;
            lock_cnt <= 4'd0;
            rvalid0  <= 1'b0;
            rvalid1  <= 1'b0;
            rdata0   <= '0;
            rdata1   <= '0;
            io_data  <= '0;
            io_valid <= 1'b0;
        end else begin
            state    <= state_nxt;
            last     <= last_nxt;
            lock_cnt <= lock_cnt_nxt;
            rvalid0  <= rd_fire & ~sel;
            rvalid1  <= rd_fire & sel;
            if (rd_fire && !sel) begin
                rdata0 <= rd_value;
            end
            if (rd_fire && sel) begin
                rdata1 <= rd_value;
            end
            io_valid <= io_fire;
            if (io_fire) begin
                io_data <= sel_wdata;
            end
        end
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_data_mem_arbiter
// Drives directed and random traffic into data_mem_arbiter. A high-level
// model (owner / held-cycle count / last winner, plus its own copy of memory
// and the output register) predicts each cycle's outputs and each read
// response into queues; a negedge monitor pops and compares.
// ---------------------------------------------------------------------------
module tb_data_mem_arbiter;
    import mem_pkg::*;

    localparam int         LOCK_MAX = 4;
    localparam logic [7:0] IO       = 8'hFF;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0, req1, we0, we1, lock0, lock1;
    logic [7:0] addr0, addr1, wdata0, wdata1;
    logic       gnt0, gnt1, rvalid0, rvalid1, mem_wr_enable, io_valid;
    logic [7:0] rdata0, rdata1, mem_address, mem_in, mem_out, io_data;

    always #5 clk = ~clk;

    data_mem_arbiter #(
        .AW(8), .DW(8), .IO_ADDR(IO), .LOCK_MAX(LOCK_MAX)
    ) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .lock0(lock0), .lock1(lock1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1),
        .rdata0(rdata0), .rdata1(rdata1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .mem_address(mem_address), .mem_in(mem_in), .mem_out(mem_out),
        .mem_wr_enable(mem_wr_enable),
        .io_data(io_data), .io_valid(io_valid)
    );

    // The external single-port Memory the arbiter drives.
    logic [7:0] mem [256];
    assign mem_out = mem[mem_address];
    always @(posedge clk) if (mem_wr_enable) mem[mem_address] <= mem_in;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flag(input string name);
        checks++;
        errors++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    typedef struct {
        int         due;
        logic       g0, g1, we;
        logic [7:0] addr, wdata;
        logic       iov;
        logic [7:0] iod;
    } cyc_exp_t;

    typedef struct {
        int         due;
        logic [7:0] data;
    } rd_exp_t;

    cyc_exp_t cq[$];
    rd_exp_t  rq0[$];
    rd_exp_t  rq1[$];

    // Reference model state.
    int         owner = -1;
    int         held  = 0;
    int         last  = 1;
    logic [7:0] mmem [256];
    logic [7:0] m_io  = 8'h00;
    logic       m_iov = 1'b0;
    bit         checking = 0;

    function automatic port_req_t mk(input logic r, input logic w, input logic l,
                                     input logic [7:0] a, input logic [7:0] d);
        port_req_t p;
        p.req = r; p.we = w; p.lock = l; p.addr = a; p.wdata = d;
        return p;
    endfunction

    // One clock cycle: drive, predict, optionally check the grant against a
    // literal (exp_g: -2 don't care, -1 none, 0/1 port), advance to posedge+1.
    task automatic step(input logic r, input port_req_t p0, input port_req_t p1, input int exp_g);
        int        g;
        port_req_t s;
        cyc_exp_t  e;
        rd_exp_t   rd;
        rst = r;
        req0 = p0.req; we0 = p0.we; lock0 = p0.lock; addr0 = p0.addr; wdata0 = p0.wdata;
        req1 = p1.req; we1 = p1.we; lock1 = p1.lock; addr1 = p1.addr; wdata1 = p1.wdata;
        g = -1;
        if (!r) begin
            if (owner == 0) g = p0.req ? 0 : -1;
            else if (owner == 1) g = p1.req ? 1 : -1;
            else if (p0.req && p1.req) g = 1 - last;
            else if (p0.req) g = 0;
            else if (p1.req) g = 1;
        end
        s = (g == 1) ? p1 : p0;
        e.due   = cyc;
        e.g0    = (g == 0);
        e.g1    = (g == 1);
        e.we    = (g >= 0) && s.we && (s.addr != IO);
        e.addr  = (g >= 0) ? s.addr : 8'h00;
        e.wdata = s.wdata;
        e.iov   = m_iov;
        e.iod   = m_io;
        cq.push_back(e);
        if (r) begin
            owner = -1; held = 0; last = 1; m_io = 8'h00; m_iov = 1'b0;
        end else begin
            m_iov = (g >= 0) && s.we && (s.addr == IO);
            if (g >= 0) begin
                if (!s.we) begin
                    rd.due  = cyc + 1;
                    rd.data = (s.addr == IO) ? m_io : mmem[s.addr];
                    if (g == 0) rq0.push_back(rd); else rq1.push_back(rd);
                end else if (s.addr == IO) begin
                    m_io = s.wdata;
                end else begin
                    mmem[s.addr] = s.wdata;
                end
            end
            if (owner >= 0) begin
                held++;
                if ((g == owner && !s.lock) || held >= LOCK_MAX) begin
                    last  = owner;
                    owner = -1;
                end
            end else if (g >= 0) begin
                last = g;
                if (s.lock) begin
                    held = 1;
                    if (held < LOCK_MAX) owner = g;
                end
            end
        end
        #1;
        if (exp_g != -2) begin
            check("gnt0_directed", gnt0, exp_g == 0);
            check("gnt1_directed", gnt1, exp_g == 1);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic rd_check(input int port, input logic rv, input logic [7:0] rd);
        rd_exp_t x;
        if (port == 0) begin
            if (rv) begin
                if (rq0.size() == 0) flag("rvalid0_spurious");
                else begin
                    x = rq0.pop_front();
                    check("rdata0", rd, x.data);
                    check("rvalid0_time", cyc, x.due);
                end
            end else if (rq0.size() > 0 && rq0[0].due <= cyc) begin
                flag("rvalid0_missing");
                void'(rq0.pop_front());
            end
        end else begin
            if (rv) begin
                if (rq1.size() == 0) flag("rvalid1_spurious");
                else begin
                    x = rq1.pop_front();
                    check("rdata1", rd, x.data);
                    check("rvalid1_time", cyc, x.due);
                end
            end else if (rq1.size() > 0 && rq1[0].due <= cyc) begin
                flag("rvalid1_missing");
                void'(rq1.pop_front());
            end
        end
    endtask

    cyc_exp_t mon_e;
    always @(negedge clk) begin
        if (checking) begin
            if (cq.size() == 0) begin
                flag("no_expectation");
            end else begin
                mon_e = cq.pop_front();
                check("cycle_tag", cyc, mon_e.due);
                check("gnt0", gnt0, mon_e.g0);
                check("gnt1", gnt1, mon_e.g1);
                check("mem_wr_enable", mem_wr_enable, mon_e.we);
                check("mem_address", mem_address, mon_e.addr);
                if (mon_e.we) check("mem_in", mem_in, mon_e.wdata);
                check("io_valid", io_valid, mon_e.iov);
                check("io_data", io_data, mon_e.iod);
            end
            rd_check(0, rvalid0, rdata0);
            rd_check(1, rvalid1, rdata1);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] raddr();
        if ($urandom_range(0, 9) == 0) return IO;
        return 8'h30 + 8'($urandom_range(0, 7));
    endfunction

    function automatic port_req_t rreq();
        return mk($urandom_range(0, 9) < 7, 1'($urandom_range(0, 1)),
                  $urandom_range(0, 2) == 0, raddr(), 8'($urandom));
    endfunction

    port_req_t idle;
    port_req_t w0, w1, l1, r0, r1;

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]  = 8'($urandom);
            mmem[i] = mem[i];
        end
        mem[8'h10]  = 8'h2A;
        mmem[8'h10] = 8'h2A;
        idle = mk(0, 0, 0, 8'h00, 8'h00);
        rst = 1'b1;
        req0 = 0; req1 = 0; we0 = 0; we1 = 0; lock0 = 0; lock1 = 0;
        addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
        repeat (2) @(posedge clk);
        #1;
        checking = 1;

        // Reset values.
        step(1, idle, idle, -1);
        check("rst_rvalid0", rvalid0, 0);
        check("rst_rvalid1", rvalid1, 0);
        check("rst_rdata0", rdata0, 0);
        check("rst_rdata1", rdata1, 0);
        check("rst_io_data", io_data, 0);
        check("rst_io_valid", io_valid, 0);
        check("rst_mem_wr_enable", mem_wr_enable, 0);

        // Single port read of preloaded 8'h10.
        step(0, mk(1, 0, 0, 8'h10, 8'h00), idle, 0);
        check("single_rvalid0", rvalid0, 1);
        check("single_rdata0", rdata0, 8'h2A);
        check("single_rvalid1", rvalid1, 0);
        step(0, idle, idle, -1);

        // Contention: both write, grants alternate starting with port 0.
        step(1, idle, idle, -1);
        w0 = mk(1, 1, 0, 8'h20, 8'hA5);
        w1 = mk(1, 1, 0, 8'h21, 8'h5A);
        step(0, w0, w1, 0);
        step(0, w0, w1, 1);
        step(0, w0, w1, 0);
        step(0, w0, w1, 1);
        check("contention_mem20", mem[8'h20], 8'hA5);
        check("contention_mem21", mem[8'h21], 8'h5A);
        step(0, mk(1, 0, 0, 8'h20, 0), mk(1, 0, 0, 8'h21, 0), 0);
        step(0, idle, mk(1, 0, 0, 8'h21, 0), 1);
        step(0, idle, idle, -1);

        // Lock: port 1 owns for LOCK_MAX cycles while port 0 waits.
        step(1, idle, idle, -1);
        l1 = mk(1, 0, 1, 8'h31, 8'h00);
        r0 = mk(1, 0, 0, 8'h10, 8'h00);
        step(0, idle, l1, 1);
        step(0, r0, l1, 1);
        step(0, r0, l1, 1);
        step(0, r0, l1, 1);
        step(0, r0, l1, 0);
        step(0, r0, l1, 1);
        for (int i = 0; i < 4; i++) step(0, idle, idle, -1);

        // MMIO write then read back.
        step(1, idle, idle, -1);
        step(0, mk(1, 1, 0, IO, 8'd13), idle, 0);
        check("mmio_io_valid", io_valid, 1);
        check("mmio_io_data", io_data, 8'd13);
        step(0, mk(1, 0, 0, IO, 8'h00), idle, 0);
        check("mmio_io_valid_once", io_valid, 0);
        check("mmio_read_rdata0", rdata0, 8'd13);
        check("mmio_mem_untouched", mem[IO], mmem[IO]);

        // Reset during OWN0 with a read pending.
        step(0, mk(1, 0, 1, 8'h11, 0), idle, 0);
        r1 = mk(1, 0, 0, 8'h12, 0);
        step(1, mk(1, 0, 1, 8'h12, 0), r1, -1);
        check("midlock_rvalid0", rvalid0, 0);
        check("midlock_io_data", io_data, 0);
        step(0, mk(1, 0, 0, 8'h13, 0), r1, 0);
        step(0, idle, idle, -1);

        // Random traffic with occasional reset.
        for (int i = 0; i < 2000; i++) begin
            step($urandom_range(0, 199) == 0, rreq(), rreq(), -2);
        end
        step(0, idle, idle, -1);
        step(0, idle, idle, -1);
        checking = 0;
        check("drain_rq0", rq0.size(), 0);
        check("drain_rq1", rq1.size(), 0);
        check("drain_cq", cq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
